hack_cpu: RTL and testbench

HACK_CPU -- requirements
Module: hack_cpu

---
 rtl/hack_pkg.sv | 41 ++++
 rtl/hack_cpu_alu.sv | 32 +++
 rtl/hack_cpu.sv | 86 ++++++++
 tb/tb_hack_cpu.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU: field positions, default widths, jump encodings.
package hack_pkg;

    localparam int unsigned W_DEF   = 16;
    localparam int unsigned AW_DEF  = 15;
    localparam int unsigned IMM_W   = 15;

    // Instruction bit positions
    localparam int unsigned BIT_CI  = 15;
    localparam int unsigned BIT_A   = 12;
    localparam int unsigned BIT_ZX  = 11;
    localparam int unsigned BIT_NX  = 10;
    localparam int unsigned BIT_ZY  = 9;
    localparam int unsigned BIT_NY  = 8;
    localparam int unsigned BIT_F   = 7;
    localparam int unsigned BIT_NO  = 6;
    localparam int unsigned BIT_DA  = 5;
    localparam int unsigned BIT_DD  = 4;
    localparam int unsigned BIT_DM  = 3;
    localparam int unsigned BIT_JLT = 2;
    localparam int unsigned BIT_JEQ = 1;
    localparam int unsigned BIT_JGT = 0;

    // Jump field encodings {jlt, jeq, jgt}
    typedef enum logic [2:0] {
        J_NULL = 3'b000,
        J_JGT  = 3'b001,
        J_JEQ  = 3'b010,
        J_JGE  = 3'b011,
        J_JLT  = 3'b100,
        J_JNE  = 3'b101,
        J_JLE  = 3'b110,
        J_JMP  = 3'b111
    } jump_e;

    // Jump decision from the {jlt, jeq, jgt} field and the ALU flags
    function automatic logic jump_cond(input logic [2:0] j, input logic zr, input logic ng);
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_alu.sv
// Hack ALU: optional zero/negate of each operand, add or AND, optional negate of result.
module hack_cpu_alu #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         zx,
    input  logic         nx,
    input  logic         zy,
    input  logic         ny,
    input  logic         f,
    input  logic         no,
    output logic [W-1:0] out,
    output logic         zr,
    output logic         ng
);

    logic [W-1:0] xz, xn, yz, yn, fo;

    // Operand conditioning, function select and flag generation
    always_comb begin
        xz  = zx ? '0 : x;
        xn  = nx ? ~xz : xz;
        yz  = zy ? '0 : y;
        yn  = ny ? ~yz : yz;
        fo  = f ? (xn + yn) : (xn & yn);
        out = no ? ~fo : fo;
        zr  = (out == '0);
        ng  = out[W-1];
    end

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: A, D and pc registers around a combinational ALU, with stall and sync reset.
module hack_cpu
    import hack_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   instr,
    input  logic          instr_valid,
    input  logic [W-1:0]  inM,
    output logic [W-1:0]  outM,
    output logic          writeM,
    output logic [AW-1:0] addressM,
    output logic [AW-1:0] pc
);

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  d_q, d_d;
    logic [AW-1:0] pc_q, pc_d;

    logic [W-1:0]  alu_y;
    logic [W-1:0]  alu_out;
    logic          alu_zr, alu_ng;
    logic          is_c, jump;

    hack_cpu_alu #(.W(W)) u_alu (
        .x   (d_q),
        .y   (alu_y),
        .zx  (instr[BIT_ZX]),
        .nx  (instr[BIT_NX]),
        .zy  (instr[BIT_ZY]),
        .ny  (instr[BIT_NY]),
        .f   (instr[BIT_F]),
        .no  (instr[BIT_NO]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Decode, operand select and next-state computation
    always_comb begin
        is_c  = instr[BIT_CI];
        alu_y = instr[BIT_A] ? inM : a_q;
        jump  = jump_cond(instr[BIT_JLT:BIT_JGT], alu_zr, alu_ng);

        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_q;

        if (instr_valid) begin
            pc_d = pc_q + AW'(1);
            if (!is_c) begin
                a_d = W'(instr[IMM_W-1:0]);
            end else begin
                if (instr[BIT_DA]) a_d = alu_out;
                if (instr[BIT_DD]) d_d = alu_out;
                // Jump target uses the pre-edge A, not a value written this cycle
                if (jump) pc_d = a_q[AW-1:0];
            end
        end
    end

    // Architectural state with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            d_q  <= '0;
            pc_q <= '0;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    // Memory-side outputs reflect current state; write is suppressed in reset and stall
    always_comb begin
        outM     = alu_out;
        writeM   = instr_valid & is_c & instr[BIT_DM] & ~rst;
        addressM = a_q[AW-1:0];
        pc       = pc_q;
    end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed self-checking bench for hack_cpu.
module tb_hack_cpu;

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 15;

    // Hand-assembled Hack instructions
    localparam logic [15:0] I_DEQA    = 16'hEC10;  // D=A
    localparam logic [15:0] I_DEQA_X  = 16'h8C10;  // D=A with bits 14:13 cleared
    localparam logic [15:0] I_MDPM    = 16'hF088;  // M=D+M
    localparam logic [15:0] I_DJEQ    = 16'hE302;  // D;JEQ
    localparam logic [15:0] I_DJLT    = 16'hE304;  // D;JLT
    localparam logic [15:0] I_D       = 16'hE300;  // D (no dest, no jump)
    localparam logic [15:0] I_DZERO   = 16'hEA90;  // D=0
    localparam logic [15:0] I_DNEG1   = 16'hEE90;  // D=-1
    localparam logic [15:0] I_AMINC   = 16'hEDEF;  // AM=A+1;JMP
    localparam logic [15:0] I_JMP     = 16'hEA87;  // 0;JMP

    logic          clk;
    logic          rst;
    logic [15:0]   instr;
    logic          instr_valid;
    logic [W-1:0]  inM;
    logic [W-1:0]  outM;
    logic          writeM;
    logic [AW-1:0] addressM;
    logic [AW-1:0] pc;

    int tests = 0;
    int fails = 0;

    hack_cpu #(.W(W), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an instruction and move to the negedge for combinational checks
    task automatic drive(input logic [15:0] i, input logic v, input logic [W-1:0] m);
        instr       = i;
        instr_valid = v;
        inM         = m;
        @(negedge clk);
    endtask

    // Advance through the active edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Execute one valid instruction with no mid-cycle checks
    task automatic exec(input logic [15:0] i);
        drive(i, 1'b1, '0);
        tick();
    endtask

    // Observe D through the ALU without changing state
    task automatic peek_d(input string tag, input logic [W-1:0] exp);
        instr       = I_D;
        instr_valid = 1'b0;
        #1;
        chk(tag, 32'(outM), 32'(exp));
    endtask

    initial begin
        rst         = 1'b1;
        instr       = 16'hFFFF;
        instr_valid = 1'b1;
        inM         = '0;

        // Reset with an M-writing instruction present
        drive(16'hFFFF, 1'b1, 16'h1234);
        chk("rst_writeM", 32'(writeM), 32'd0);
        tick();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_addr", 32'(addressM), 32'd0);
        peek_d("rst_d", 16'd0);
        rst = 1'b0;

        // @21 ; D=A
        drive(16'd21, 1'b1, '0);
        chk("a21_writeM", 32'(writeM), 32'd0);
        chk("a21_pc0", 32'(pc), 32'd0);
        tick();
        chk("a21_addr", 32'(addressM), 32'd21);
        chk("a21_pc", 32'(pc), 32'd1);
        drive(I_DEQA, 1'b1, '0);
        chk("deqa_writeM", 32'(writeM), 32'd0);
        chk("deqa_outM", 32'(outM), 32'd21);
        tick();
        chk("deqa_pc", 32'(pc), 32'd2);
        chk("deqa_addr", 32'(addressM), 32'd21);
        peek_d("deqa_d", 16'd21);

        // D=5, A=100, M=D+M with inM=7
        exec(16'd5);
        exec(I_DEQA);
        exec(16'd100);
        drive(I_MDPM, 1'b1, 16'd7);
        chk("mdpm_outM", 32'(outM), 32'd12);
        chk("mdpm_writeM", 32'(writeM), 32'd1);
        chk("mdpm_addr", 32'(addressM), 32'd100);
        tick();
        chk("mdpm_addr_after", 32'(addressM), 32'd100);
        peek_d("mdpm_d_after", 16'd5);
        chk("mdpm_pc", 32'(pc), 32'd6);

        // Conditional jumps against A=40
        exec(I_DZERO);
        exec(16'd40);
        exec(I_DJEQ);
        chk("jeq_taken_pc", 32'(pc), 32'd40);
        exec(16'd3);
        exec(I_DEQA);
        exec(16'd40);
        exec(I_DJEQ);
        chk("jeq_not_taken_pc", 32'(pc), 32'd44);
        exec(I_DNEG1);
        exec(I_DJLT);
        chk("jlt_taken_pc", 32'(pc), 32'd40);

        // AM=A+1;JMP with A=7: write and jump use the old A
        exec(16'd7);
        drive(I_AMINC, 1'b1, '0);
        chk("aminc_outM", 32'(outM), 32'd8);
        chk("aminc_addr", 32'(addressM), 32'd7);
        chk("aminc_writeM", 32'(writeM), 32'd1);
        tick();
        chk("aminc_a_after", 32'(addressM), 32'd8);
        chk("aminc_pc", 32'(pc), 32'd7);

        // Three-cycle stall with M=D+M present (D=-1, inM=7 -> 6)
        for (int k = 0; k < 3; k++) begin
            drive(I_MDPM, 1'b0, 16'd7);
            chk("stall_writeM", 32'(writeM), 32'd0);
            chk("stall_outM", 32'(outM), 32'd6);
            tick();
            chk("stall_pc", 32'(pc), 32'd7);
            chk("stall_addr", 32'(addressM), 32'd8);
        end
        drive(I_MDPM, 1'b1, 16'd7);
        chk("resume_writeM", 32'(writeM), 32'd1);
        tick();
        chk("resume_pc", 32'(pc), 32'd8);
        peek_d("resume_d", 16'hFFFF);

        // Bits 14:13 of a C-instruction are don't-care
        exec(16'd9);
        exec(I_DEQA_X);
        peek_d("ignore_bits_d", 16'd9);

        // pc wrap after 32768 A-instructions from reset
        rst = 1'b1;
        exec(I_JMP);
        rst = 1'b0;
        instr       = 16'h7FFF;
        instr_valid = 1'b1;
        for (int n = 0; n < 32767; n++) begin
            @(posedge clk);
        end
        #1;
        chk("wrap_pc_max", 32'(pc), 32'd32767);
        chk("wrap_addr", 32'(addressM), 32'h7FFF);
        exec(16'h7FFF);
        chk("wrap_pc_zero", 32'(pc), 32'd0);

        // Reset during a JMP overrides every update
        exec(16'd9);
        exec(I_DEQA);
        exec(16'd300);
        rst = 1'b1;
        drive(I_JMP, 1'b1, '0);
        chk("rstjmp_writeM", 32'(writeM), 32'd0);
        tick();
        chk("rstjmp_pc", 32'(pc), 32'd0);
        chk("rstjmp_addr", 32'(addressM), 32'd0);
        peek_d("rstjmp_d", 16'd0);
        rst = 1'b0;

        // First instruction after reset runs from pc=0
        drive(16'd5, 1'b1, '0);
        chk("post_rst_pc0", 32'(pc), 32'd0);
        tick();
        chk("post_rst_pc1", 32'(pc), 32'd1);
        chk("post_rst_addr", 32'(addressM), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
